stopwatch_display: RTL and testbench
====================================

# stopwatch_display

Multiplexed 4-digit seven-segment driver for the stopwatch time value, shown as MM:SS. Sits directly downstream of the stopwatch counter: consumes its binary `sec`/`min` outputs, splits each into decimal digits, and time-multiplexes them onto a common-anode display with per-digit dead time. Inputs are snapshotted once per frame so a display frame never mixes two different times.

## Interface
- `REFRESH_DIV`, 50000: clock cycles per digit slot; must be ≥ 2.
- `DEAD_CYCLES`, 16: blanked cycles at the start of each slot; must be < `REFRESH_DIV`.
- `clk` input 1: system clock. One clock domain.
- `rst_n` input 1: asynchronous, active-low reset.
- `sec` input 6: seconds value, binary.
- `min` input 6: minutes value, binary.
- `seg` output 7: segments {g,f,e,d,c,b,a}, active-low, registered.
- `an` output 4: digit anodes, active-low one-hot, registered. `an[0]` is seconds ones, `an[1]` is seconds tens, `an[2]` is minutes ones, `an[3]` is minutes tens.
- `dp` output 1: decimal point, used as the colon. Active-low, registered.

## Operation
- State:
  - `cnt`: slot counter, 0..`REFRESH_DIV`-1.
  - `d`: digit index, 0..3.
  - `snap_sec`, `snap_min`: 6-bit snapshot registers.
- Counting:
  - `cnt` increments every cycle.
  - At `cnt`==`REFRESH_DIV`-1, `cnt` returns to 0 and `d` increments mod 4 (3 wraps to 0).
- Snapshot: `snap_sec` and `snap_min` load `sec` and `min` on the edge where `cnt`==0 and `d`==0 (start of frame). They hold at all other times.
- Digit value, computed from the snapshot:
  - d0 = `snap_sec` % 10
  - d1 = `snap_sec` / 10
  - d2 = `snap_min` % 10
  - d3 = `snap_min` / 10
  - Inputs 60..63 are not special: tens digit shows 6.
- Segment encoding (hex, active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
- Two-state slot FSM, derived from `cnt`:
  - BLANK (`cnt` < `DEAD_CYCLES`): `an`=4'hF, `seg`=7'h7F, `dp`=1.
  - SHOW (`cnt` ≥ `DEAD_CYCLES`): `an` has bit `d` low and all others high. `seg` shows the encoding of digit `d`.
- Colon: `dp`=0 only in SHOW with `d`==2 and `snap_sec[0]`==0 (blinks at 0.5 Hz rate of seconds). Otherwise `dp`=1.
- Input changes mid-frame have no effect until the next frame start.
- Reset (asynchronous, any time, including mid-slot):
  - `cnt`=0, `d`=0, snapshots=0.
  - `seg`=7'h7F, `an`=4'hF, `dp`=1.

## Timing
- All outputs are registered and lag the internal `cnt`/`d` state by one cycle.
- Slot period: `REFRESH_DIV` cycles. Frame period: 4×`REFRESH_DIV` cycles.
- Visible SHOW time per slot: `REFRESH_DIV`−`DEAD_CYCLES` cycles.
- Between any two consecutive SHOW intervals, `an`=4'hF for exactly `DEAD_CYCLES` cycles. Two anodes are never low in the same cycle.
- First edge after `rst_n` rises:
  - snapshot loads (`cnt`==0, `d`==0).
  - Outputs stay blank through output cycle `DEAD_CYCLES`.
  - `an`=4'b1110 first appears `DEAD_CYCLES`+1 edges after reset release.
- Snapshot-to-display latency: the value captured at frame start appears on digit 0 `DEAD_CYCLES`+1 cycles later.

## Configuration
- `LEADING_ZERO_BLANK_EN`:
  - Defined: when d3 == 0, slot 3 drives `seg`=7'h7F in SHOW. `an[3]` still goes low and timing is unchanged.
  - Undefined: d3 == 0 displays "0" (7'h40).
  - All other digits are always shown.

## Test plan
All scenarios use `REFRESH_DIV`=8, `DEAD_CYCLES`=2.
- Reset, then release with `sec`=0, `min`=0:
  - Outputs stay at `seg`=7F, `an`=F, `dp`=1 for 3 edges.
  - Then `an` cycles E,F,F,D,F,F,B,F,F,7 with 6-cycle SHOW windows and 2-cycle blanks.
  - `seg`=40 in every SHOW window.
- `sec`=37, `min`=12: per frame, `seg` shows 78 (7), 30 (3), 24 (2), 79 (1) on `an` E, D, B, 7. `dp` stays 1 (37 is odd).
- `sec`=36: `dp`=0 only during the `an`=B SHOW window. `sec`=59, `min`=63 shows 10 (9), 12 (5), 30 (3), 02 (6).
- Change `sec` from 10 to 11 mid-frame (`d`=1): the rest of that frame still shows 0/1. The next frame shows 1/1.
- Assert `rst_n` low mid-SHOW: `seg`=7F, `an`=F, `dp`=1 immediately, without waiting for a clock edge. After release, the sequence restarts at digit 0.
- With `LEADING_ZERO_BLANK_EN` and `min`=5: slot 3 has `an`=7 with `seg`=7F. With `min`=15, `seg`=79. Without the macro, `min`=5 gives `seg`=40 in slot 3.

Source files
------------

// File: rtl/stopwatch_display.sv
// stopwatch_display
// Multiplexed 4-digit common-anode seven-segment driver for an MM:SS stopwatch.
// Takes the binary sec/min values from the stopwatch counter and splits each
// into decimal digits. Digits are time-multiplexed one per slot. Each slot
// begins with a short blanked dead time so that anode switching never ghosts
// the previous digit's segments.
// The inputs are snapshotted once per frame, at slot 0 / count 0, so a single
// frame never mixes two different time values.
//
// Optional feature macro:
//   LEADING_ZERO_BLANK_EN - when defined, a zero minutes-tens digit is blanked
//                           (segments off) while its anode timing is kept.
//
// All outputs (seg, an, dp) are active-low and registered. They lag the
// internal slot counter / digit index by one clock.

module stopwatch_display #(
    parameter int REFRESH_DIV = 50000,   // clocks per digit slot, >= 2
    parameter int DEAD_CYCLES = 16       // blanked clocks at slot start, < REFRESH_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    // Slot phase: dead time first, then the digit is driven.
    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } slot_state_t;

    localparam int                CNT_W       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX     = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]  DEAD_VAL    = CNT_W'(DEAD_CYCLES);
    localparam slot_state_t       RESET_STATE = (DEAD_CYCLES > 0) ? BLANK : SHOW;
    localparam logic [6:0]        SEG_OFF     = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} pattern for one decimal digit.
    // Non-decimal codes cannot occur but map to all-off for safety.
    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = 7'h40;
            4'd1:    pattern = 7'h79;
            4'd2:    pattern = 7'h24;
            4'd3:    pattern = 7'h30;
            4'd4:    pattern = 7'h19;
            4'd5:    pattern = 7'h12;
            4'd6:    pattern = 7'h02;
            4'd7:    pattern = 7'h78;
            4'd8:    pattern = 7'h00;
            4'd9:    pattern = 7'h10;
            default: pattern = SEG_OFF;
        endcase
        return pattern;
    endfunction

    // Units digit of a 0..63 value.
    function automatic logic [3:0] ones_of(input logic [5:0] value);
        return 4'(value % 6'd10);
    endfunction

    // Tens digit of a 0..63 value (60..63 give 6, nothing special).
    function automatic logic [3:0] tens_of(input logic [5:0] value);
        return 4'(value / 6'd10);
    endfunction

    logic [CNT_W-1:0] cnt;
    logic [1:0]       d;
    slot_state_t      state;
    logic [5:0]       snap_sec;
    logic [5:0]       snap_min;

    logic [CNT_W-1:0] cnt_next;
    logic [1:0]       d_next;
    slot_state_t      state_next;
    logic             cnt_wrap;
    logic             frame_start;
    logic [5:0]       view_sec;
    logic [5:0]       view_min;
    logic [3:0]       digit;
    logic [6:0]       digit_seg;
    logic             colon_on;
    logic [3:0]       anode_sel;

    // Next slot position, and the digit/segment/anode values for the current slot.
    // On the frame-start clock the snapshot is being loaded in this same edge,
    // so the incoming inputs are used directly. That keeps the displayed
    // value consistent with the snapshot even when the dead time is zero.
    always_comb begin
        cnt_wrap    = (cnt == CNT_MAX);
        cnt_next    = cnt_wrap ? '0 : cnt + 1'b1;
        d_next      = cnt_wrap ? d + 2'd1 : d;
        state_next  = (cnt_next < DEAD_VAL) ? BLANK : SHOW;

        frame_start = (cnt == '0) && (d == 2'd0);
        view_sec    = frame_start ? sec : snap_sec;
        view_min    = frame_start ? min : snap_min;

        case (d)
            2'd0:    digit = ones_of(view_sec);
            2'd1:    digit = tens_of(view_sec);
            2'd2:    digit = ones_of(view_min);
            default: digit = tens_of(view_min);
        endcase

        digit_seg = seg_encode(digit);
`ifdef LEADING_ZERO_BLANK_EN
        if ((d == 2'd3) && (digit == 4'd0)) begin
            digit_seg = SEG_OFF;
        end
`endif

        colon_on  = (d == 2'd2) && !view_sec[0];
        anode_sel = ~(4'b0001 << d);
    end

    // Slot FSM with counter, digit index, frame snapshot and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            d        <= 2'd0;
            state    <= RESET_STATE;
            snap_sec <= 6'd0;
            snap_min <= 6'd0;
            seg      <= SEG_OFF;
            an       <= 4'hF;
            dp       <= 1'b1;
        end else begin
            cnt   <= cnt_next;
            d     <= d_next;
            state <= state_next;

            if (frame_start) begin
                snap_sec <= sec;
                snap_min <= min;
            end

            case (state)
                SHOW: begin
                    seg <= digit_seg;
                    an  <= anode_sel;
                    dp  <= !colon_on;
                end
                default: begin
                    seg <= SEG_OFF;
                    an  <= 4'hF;
                    dp  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stopwatch_display.sv
// tb_stopwatch_display
// Self-checking bench for stopwatch_display with REFRESH_DIV=8, DEAD_CYCLES=2.
// Every cycle is compared against a frame-position model. A set of
// hand-computed literal expectations pins the model at known points.
// Honours LEADING_ZERO_BLANK_EN when the macro is defined for the build.

module tb_stopwatch_display;

    localparam int RD    = 8;
    localparam int DEAD  = 2;
    localparam int FRAME = 4 * RD;

    localparam logic [6:0] SEG_TABLE [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] ZERO_TENS_SEG = 7'h7F;
`else
    localparam logic [6:0] ZERO_TENS_SEG = 7'h40;
`endif

    logic       clk;
    logic       rst_n;
    logic [5:0] sec;
    logic [5:0] min;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    int vectors;
    int miscompares;

    int          t_edges;
    int          m_sec;
    int          m_min;
    logic [11:0] exp_out;

    stopwatch_display #(
        .REFRESH_DIV (RD),
        .DEAD_CYCLES (DEAD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sec   (sec),
        .min   (min),
        .seg   (seg),
        .an    (an),
        .dp    (dp)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected {seg, an, dp} for a position within the frame, given the frame's time value.
    function automatic logic [11:0] modelOut(input int pos, input int s, input int m);
        int         slot;
        int         phase;
        int         value;
        int         digit;
        logic [6:0] sg;
        logic [3:0] a;
        logic       p;
        slot  = pos / RD;
        phase = pos % RD;
        if (phase < DEAD) begin
            return {7'h7F, 4'hF, 1'b1};
        end
        value = (slot < 2) ? s : m;
        digit = (slot % 2 == 0) ? (value % 10) : (value / 10);
        sg    = SEG_TABLE[digit];
`ifdef LEADING_ZERO_BLANK_EN
        if (slot == 3 && digit == 0) begin
            sg = 7'h7F;
        end
`endif
        a       = 4'hF;
        a[slot] = 1'b0;
        p       = !(slot == 2 && (s % 2) == 0);
        return {sg, a, p};
    endfunction

    // Reference model: edges since reset give the frame position; inputs captured at position 0.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_edges <= 0;
            m_sec   <= 0;
            m_min   <= 0;
            exp_out <= 12'hFFF;
        end else if ((t_edges % FRAME) == 0) begin
            m_sec   <= int'(sec);
            m_min   <= int'(min);
            exp_out <= modelOut(0, int'(sec), int'(min));
            t_edges <= t_edges + 1;
        end else begin
            exp_out <= modelOut(t_edges % FRAME, m_sec, m_min);
            t_edges <= t_edges + 1;
        end
    end

    task automatic applyStimulus(input int s, input int m);
        sec = 6'(s);
        min = 6'(m);
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [6:0] eSeg,
                               input logic [3:0] eAn, input logic eDp);
        vectors++;
        if (seg !== eSeg || an !== eAn || dp !== eDp) begin
            miscompares++;
            $display("[TB] FAIL %s: got seg=%h an=%h dp=%b, expected seg=%h an=%h dp=%b",
                     name, seg, an, dp, eSeg, eAn, eDp);
        end
    endtask

    // Reset asserted away from any edge; outputs must blank at once, no clock needed.
    task automatic resetDut();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 checkOutput("reset_async", 7'h7F, 4'hF, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic mainSequence();
        int n;
        int r;

        $display("[TB] scenario: zeros after reset");
        applyStimulus(0, 0);
        resetDut();
        waitEdges(2);  checkOutput("zero_t2_blank", 7'h7F, 4'hF, 1'b1);
        waitEdges(1);  checkOutput("zero_t3_d0",    7'h40, 4'hE, 1'b1);
        waitEdges(5);  checkOutput("zero_t8_d0",    7'h40, 4'hE, 1'b1);
        waitEdges(1);  checkOutput("zero_t9_blank", 7'h7F, 4'hF, 1'b1);
        waitEdges(2);  checkOutput("zero_t11_d1",   7'h40, 4'hD, 1'b1);
        waitEdges(8);  checkOutput("zero_t19_d2",   7'h40, 4'hB, 1'b0);
        waitEdges(8);  checkOutput("zero_t27_d3",   ZERO_TENS_SEG, 4'h7, 1'b1);

        $display("[TB] scenario: 12:37");
        applyStimulus(37, 12);
        resetDut();
        waitEdges(3);  checkOutput("t1237_d0", 7'h78, 4'hE, 1'b1);
        waitEdges(8);  checkOutput("t1237_d1", 7'h30, 4'hD, 1'b1);
        waitEdges(8);  checkOutput("t1237_d2", 7'h24, 4'hB, 1'b1);
        waitEdges(8);  checkOutput("t1237_d3", 7'h79, 4'h7, 1'b1);

        $display("[TB] scenario: 12:36 colon");
        applyStimulus(36, 12);
        resetDut();
        waitEdges(11); checkOutput("t1236_d1", 7'h30, 4'hD, 1'b1);
        waitEdges(8);  checkOutput("t1236_d2_colon", 7'h24, 4'hB, 1'b0);

        $display("[TB] scenario: 63:59");
        applyStimulus(59, 63);
        resetDut();
        waitEdges(3);  checkOutput("t6359_d0", 7'h10, 4'hE, 1'b1);
        waitEdges(8);  checkOutput("t6359_d1", 7'h12, 4'hD, 1'b1);
        waitEdges(8);  checkOutput("t6359_d2", 7'h30, 4'hB, 1'b1);
        waitEdges(8);  checkOutput("t6359_d3", 7'h02, 4'h7, 1'b1);

        $display("[TB] scenario: mid-frame input change");
        applyStimulus(10, 0);
        resetDut();
        waitEdges(3);  checkOutput("mid_d0_old", 7'h40, 4'hE, 1'b1);
        waitEdges(6);
        applyStimulus(11, 0);
        waitEdges(2);  checkOutput("mid_d1_old",  7'h79, 4'hD, 1'b1);
        waitEdges(24); checkOutput("mid_next_d0", 7'h79, 4'hE, 1'b1);

        $display("[TB] scenario: reset during SHOW");
        applyStimulus(37, 12);
        resetDut();
        waitEdges(5);  checkOutput("pre_reset_show", 7'h78, 4'hE, 1'b1);
        #2 rst_n = 1'b0;
        #1 checkOutput("reset_mid_show", 7'h7F, 4'hF, 1'b1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        waitEdges(2);  checkOutput("restart_t2", 7'h7F, 4'hF, 1'b1);
        waitEdges(1);  checkOutput("restart_t3", 7'h78, 4'hE, 1'b1);

        $display("[TB] scenario: minutes tens digit");
        applyStimulus(0, 5);
        resetDut();
        waitEdges(27); checkOutput("min5_d3",  ZERO_TENS_SEG, 4'h7, 1'b1);
        applyStimulus(0, 15);
        resetDut();
        waitEdges(27); checkOutput("min15_d3", 7'h79, 4'h7, 1'b1);

        $display("[TB] scenario: randomized inputs and resets");
        for (int i = 0; i < 200; i++) begin
            n = int'($urandom_range(1, 20));
            waitEdges(n);
            r = int'($urandom_range(0, 14));
            if (r == 0) begin
                #2 rst_n = 1'b0;
                #1 checkOutput("rand_reset", 7'h7F, 4'hF, 1'b1);
                @(posedge clk);
                #3 rst_n = 1'b1;
            end else if (r < 8) begin
                applyStimulus(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
            end
        end
        waitEdges(2 * FRAME);
    endtask

    // Drives the scenarios while a parallel thread compares every cycle against the model.
    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b1;
        sec         = 6'd0;
        min         = 6'd0;
        #1 rst_n    = 1'b0;
        #1;
        fork
            begin
                forever begin
                    @(negedge clk);
                    vectors++;
                    if ({seg, an, dp} !== exp_out) begin
                        miscompares++;
                        $display("[TB] FAIL cycle_model t=%0d: got seg=%h an=%h dp=%b, expected seg=%h an=%h dp=%b",
                                 t_edges, seg, an, dp, exp_out[11:5], exp_out[4:1], exp_out[0]);
                    end
                end
            end
            begin
                mainSequence();
            end
        join_any
        disable fork;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
